// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_if
// Description : Stall-request / redirect bundle between the pipeline and its
//               hazard controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_ctrl_if #(
    parameter int STALL_CNT_W = 32,
    parameter int FLUSH_CNT_W = 16
);
    logic                   stallreq_if;
    logic                   stallreq_id;
    logic                   stallreq_ex;
    logic                   stallreq_mem;
    logic                   branch_flag_i;
    logic [31:0]            branch_target_i;
    logic [5:0]             stall;
    logic                   flush;
    logic [31:0]            new_pc_o;
    logic                   new_pc_valid;
    logic [STALL_CNT_W-1:0] stall_cycles;
    logic [FLUSH_CNT_W-1:0] flush_count;

    // Pipeline side: raises requests, consumes stall/flush/redirect.
    modport master (
        output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        output branch_flag_i, branch_target_i,
        input  stall, flush, new_pc_o, new_pc_valid, stall_cycles, flush_count
    );

    // Controller side.
    modport slave (
        input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        input  branch_flag_i, branch_target_i,
        output stall, flush, new_pc_o, new_pc_valid, stall_cycles, flush_count
    );
endinterface
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl
// Description : Pipeline hazard controller: stall arbitration, branch flush
//               and deferred redirect replay, saturating perf counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl #(
    parameter int STALL_CNT_W = 32,
    parameter int FLUSH_CNT_W = 16
) (
    input  logic       clk,
    input  logic       rst,
    pipe_ctrl_if.slave bus
);
    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        WAIT_IF = 1'b1
    } state_t;

    localparam logic [5:0]             c_stall_mem = 6'b011111;
    localparam logic [5:0]             c_stall_ex  = 6'b001111;
    localparam logic [5:0]             c_stall_id  = 6'b000111;
    localparam logic [5:0]             c_stall_if  = 6'b000011;
    localparam logic [STALL_CNT_W-1:0] c_stall_max = '1;
    localparam logic [FLUSH_CNT_W-1:0] c_flush_max = '1;

    state_t                 r_state;
    logic [31:0]            r_pend_pc;
    logic [STALL_CNT_W-1:0] r_stall_cycles;
    logic [FLUSH_CNT_W-1:0] r_flush_count;

    state_t      w_next_state;
    logic        w_br_ok;
    logic        w_id_req;
    logic        w_pend_load;
    logic        w_flush;
    logic        w_pc_valid;
    logic [31:0] w_new_pc;
    logic [5:0]  w_stall;

    assign w_br_ok = bus.branch_flag_i & ~bus.stallreq_mem & ~bus.stallreq_ex;

    always_comb begin
        w_next_state = r_state;
        w_id_req     = bus.stallreq_id;
        w_pend_load  = 1'b0;
        w_flush      = 1'b0;
        w_pc_valid   = 1'b0;
        w_new_pc     = 32'd0;

        case (r_state)
            IDLE: begin
                if (w_br_ok) begin
                    // The instruction in ID is on the wrong path, so its
                    // load-use hazard must not hold the pipe.
                    w_flush  = 1'b1;
                    w_id_req = 1'b0;
                    if (!bus.stallreq_if) begin
                        w_pc_valid = 1'b1;
                        w_new_pc   = bus.branch_target_i;
                    end else begin
                        w_pend_load  = 1'b1;
                        w_next_state = WAIT_IF;
                    end
                end
            end
            WAIT_IF: begin
                w_pend_load = w_br_ok;
                if (!bus.stallreq_if && !bus.stallreq_mem && !bus.stallreq_ex) begin
                    // Replay; a branch arriving this very cycle is the newest.
                    w_flush      = 1'b1;
                    w_pc_valid   = 1'b1;
                    w_new_pc     = w_br_ok ? bus.branch_target_i : r_pend_pc;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase

        if      (bus.stallreq_mem) w_stall = c_stall_mem;
        else if (bus.stallreq_ex)  w_stall = c_stall_ex;
        else if (w_id_req)         w_stall = c_stall_id;
        else if (bus.stallreq_if)  w_stall = c_stall_if;
        else                       w_stall = 6'd0;

        // Outputs are forced quiet for as long as reset is held.
        if (!rst) begin
            w_stall    = 6'd0;
            w_flush    = 1'b0;
            w_pc_valid = 1'b0;
            w_new_pc   = 32'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= IDLE;
            r_pend_pc      <= 32'd0;
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_pend_load) begin
                r_pend_pc <= bus.branch_target_i;
            end
            if ((w_stall != 6'd0) && (r_stall_cycles != c_stall_max)) begin
                r_stall_cycles <= r_stall_cycles + STALL_CNT_W'(1);
            end
            if (w_flush && (r_flush_count != c_flush_max)) begin
                r_flush_count <= r_flush_count + FLUSH_CNT_W'(1);
            end
        end
    end

    assign bus.stall        = w_stall;
    assign bus.flush        = w_flush;
    assign bus.new_pc_o     = w_new_pc;
    assign bus.new_pc_valid = w_pc_valid;
    assign bus.stall_cycles = r_stall_cycles;
    assign bus.flush_count  = r_flush_count;
endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_ctrl
// Description : Directed bench for pipe_ctrl with a behavioural model and
//               literal spot checks; a narrow-counter copy shows saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_ctrl_if #(.STALL_CNT_W(32), .FLUSH_CNT_W(16)) bus   ();
    pipe_ctrl_if #(.STALL_CNT_W(3),  .FLUSH_CNT_W(2))  bus_s ();

    pipe_ctrl #(.STALL_CNT_W(32), .FLUSH_CNT_W(16)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    pipe_ctrl #(.STALL_CNT_W(3), .FLUSH_CNT_W(2)) u_dut_s (
        .clk (clk),
        .rst (rst),
        .bus (bus_s)
    );

    assign bus_s.stallreq_if     = bus.stallreq_if;
    assign bus_s.stallreq_id     = bus.stallreq_id;
    assign bus_s.stallreq_ex     = bus.stallreq_ex;
    assign bus_s.stallreq_mem    = bus.stallreq_mem;
    assign bus_s.branch_flag_i   = bus.branch_flag_i;
    assign bus_s.branch_target_i = bus.branch_target_i;

    int n_checks = 0;
    int n_pass   = 0;

    // Literal expectations armed by the stimulus for the current cycle.
    bit          lit_stall_en, lit_redir_en, lit_fc_en, lit_sc_en, lit_scs_en;
    logic [5:0]  lit_stall;
    logic        lit_flush, lit_valid;
    logic [31:0] lit_pc;
    longint      lit_fc, lit_sc, lit_scs;

    // Model state: whether a redirect is waiting, its target, counter values.
    bit          m_pend;
    logic [31:0] m_pc;
    longint      m_sc, m_fc, m_sc_s, m_fc_s;

    logic [5:0]  e_stall;
    logic        e_flush, e_valid;
    logic [31:0] e_pc, newest;
    bit          br_ok, kill_id, replay;
    int          depth;

    function automatic longint sat_inc(input longint v, input int w);
        longint lim;
        lim = (longint'(1) << w) - 1;
        return (v >= lim) ? v : v + 1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            m_pend = 1'b0; m_pc = 32'd0;
            m_sc = 0; m_fc = 0; m_sc_s = 0; m_fc_s = 0;
            e_stall = 6'd0; e_flush = 1'b0; e_valid = 1'b0; e_pc = 32'd0;
        end else begin
            br_ok = bus.branch_flag_i && !bus.stallreq_mem && !bus.stallreq_ex;
            if (!m_pend) begin
                kill_id = br_ok;
                replay  = 1'b0;
                e_flush = br_ok;
                e_valid = br_ok && !bus.stallreq_if;
                newest  = bus.branch_target_i;
            end else begin
                kill_id = 1'b0;
                replay  = !bus.stallreq_if && !bus.stallreq_mem && !bus.stallreq_ex;
                newest  = br_ok ? bus.branch_target_i : m_pc;
                e_flush = replay;
                e_valid = replay;
            end
            e_pc = e_valid ? newest : 32'd0;
            // Number of stages held, counted from pc onward.
            depth = bus.stallreq_mem ? 5 : bus.stallreq_ex ? 4 :
                    (bus.stallreq_id && !kill_id) ? 3 : bus.stallreq_if ? 2 : 0;
            e_stall = 6'((1 << depth) - 1);
        end

        chk("stall",        64'(bus.stall),          64'(e_stall));
        chk("flush",        64'(bus.flush),          64'(e_flush));
        chk("new_pc_valid", 64'(bus.new_pc_valid),   64'(e_valid));
        chk("new_pc_o",     64'(bus.new_pc_o),       64'(e_pc));
        chk("stall_cycles", 64'(bus.stall_cycles),   64'(m_sc));
        chk("flush_count",  64'(bus.flush_count),    64'(m_fc));
        chk("s_stall",      64'(bus_s.stall),        64'(e_stall));
        chk("s_new_pc_o",   64'(bus_s.new_pc_o),     64'(e_pc));
        chk("s_stall_cyc",  64'(bus_s.stall_cycles), 64'(m_sc_s));
        chk("s_flush_cnt",  64'(bus_s.flush_count),  64'(m_fc_s));

        if (lit_stall_en) chk("lit_stall", 64'(bus.stall), 64'(lit_stall));
        if (lit_redir_en) begin
            chk("lit_flush", 64'(bus.flush),        64'(lit_flush));
            chk("lit_valid", 64'(bus.new_pc_valid), 64'(lit_valid));
            chk("lit_pc",    64'(bus.new_pc_o),     64'(lit_pc));
        end
        if (lit_fc_en)  chk("lit_flush_count",  64'(bus.flush_count),    64'(lit_fc));
        if (lit_sc_en)  chk("lit_stall_cycles", 64'(bus.stall_cycles),   64'(lit_sc));
        if (lit_scs_en) chk("lit_sat_stall",    64'(bus_s.stall_cycles), 64'(lit_scs));

        if (rst) begin
            if (!m_pend) begin
                m_pend = br_ok && bus.stallreq_if;
                if (m_pend) m_pc = bus.branch_target_i;
            end else begin
                m_pend = !replay;
                m_pc   = newest;
            end
            if (e_stall != 6'd0) begin
                m_sc   = sat_inc(m_sc, 32);
                m_sc_s = sat_inc(m_sc_s, 3);
            end
            if (e_flush) begin
                m_fc   = sat_inc(m_fc, 16);
                m_fc_s = sat_inc(m_fc_s, 2);
            end
        end
    end

    task automatic step(input bit fi, input bit di, input bit ei, input bit mi,
                        input bit bi, input logic [31:0] tg);
        @(posedge clk);
        #1;
        bus.stallreq_if     = fi;
        bus.stallreq_id     = di;
        bus.stallreq_ex     = ei;
        bus.stallreq_mem    = mi;
        bus.branch_flag_i   = bi;
        bus.branch_target_i = tg;
        lit_stall_en = 1'b0; lit_redir_en = 1'b0;
        lit_fc_en = 1'b0; lit_sc_en = 1'b0; lit_scs_en = 1'b0;
    endtask

    task automatic exp_stall(input logic [5:0] v);
        lit_stall_en = 1'b1;
        lit_stall    = v;
    endtask

    task automatic exp_redir(input logic f, input logic v, input logic [31:0] pc);
        lit_redir_en = 1'b1;
        lit_flush = f; lit_valid = v; lit_pc = pc;
    endtask

    initial begin
        rst = 1'b0;
        bus.stallreq_if = 1'b0; bus.stallreq_id = 1'b0; bus.stallreq_ex = 1'b0;
        bus.stallreq_mem = 1'b0; bus.branch_flag_i = 1'b0; bus.branch_target_i = 32'd0;

        // Outputs stay quiet under reset even with every input active.
        step(1, 1, 1, 1, 1, 32'hDEAD_BEEF); exp_stall(6'd0); exp_redir(0, 0, 0);
        step(1, 1, 0, 0, 1, 32'h0000_0010); exp_stall(6'd0); exp_redir(0, 0, 0);
        step(0, 0, 0, 0, 0, 32'd0); #2 rst = 1'b1;

        // Priority
        step(1, 1, 1, 1, 0, 32'd0); exp_stall(6'b011111);
        step(1, 1, 1, 0, 0, 32'd0); exp_stall(6'b001111);
        step(1, 1, 0, 0, 0, 32'd0); exp_stall(6'b000111);
        step(1, 0, 0, 0, 0, 32'd0); exp_stall(6'b000011);
        step(0, 0, 0, 0, 0, 32'd0); exp_stall(6'b000000);

        // Direct branch
        step(0, 0, 0, 0, 1, 32'h40); exp_redir(1, 1, 32'h40);
        lit_fc_en = 1'b1; lit_fc = 0;
        step(0, 0, 0, 0, 0, 32'd0); lit_fc_en = 1'b1; lit_fc = 1;

        // Deferred branch
        step(1, 0, 0, 0, 1, 32'h80); exp_redir(1, 0, 0); exp_stall(6'b000011);
        step(1, 0, 0, 0, 0, 32'd0);  exp_redir(0, 0, 0);
        step(1, 0, 0, 0, 0, 32'd0);  exp_redir(0, 0, 0);
        step(0, 0, 0, 0, 0, 32'd0);  exp_redir(1, 1, 32'h80);
        step(0, 0, 0, 0, 0, 32'd0);  exp_redir(0, 0, 0);
        lit_fc_en = 1'b1; lit_fc = 3;

        // Branch blocked by mem, then taken
        step(0, 0, 0, 1, 1, 32'h100); exp_redir(0, 0, 0); exp_stall(6'b011111);
        step(0, 0, 0, 0, 1, 32'h100); exp_redir(1, 1, 32'h100);

        // Load-use masked by branch
        step(0, 1, 0, 0, 1, 32'h200); exp_stall(6'd0); exp_redir(1, 1, 32'h200);

        // Newest pending redirect wins
        step(1, 0, 0, 0, 1, 32'h300); exp_redir(1, 0, 0);
        step(1, 0, 0, 0, 1, 32'h340); exp_redir(0, 0, 0);
        step(0, 0, 0, 0, 0, 32'd0);   exp_redir(1, 1, 32'h340);

        // Replay held off by mem stall
        step(1, 0, 0, 0, 1, 32'h400); exp_redir(1, 0, 0);
        step(0, 0, 0, 1, 0, 32'd0);   exp_redir(0, 0, 0); exp_stall(6'b011111);
        step(0, 0, 0, 0, 0, 32'd0);   exp_redir(1, 1, 32'h400);

        // Reset mid-cycle while waiting discards the pending redirect
        step(1, 0, 0, 0, 1, 32'h500); exp_redir(1, 0, 0);
        step(1, 0, 0, 0, 0, 32'd0);
        #1 rst = 1'b0;
        exp_stall(6'd0); exp_redir(0, 0, 0);
        lit_sc_en = 1'b1; lit_sc = 0; lit_fc_en = 1'b1; lit_fc = 0;
        step(0, 0, 0, 0, 0, 32'd0); #2 rst = 1'b1;
        exp_redir(0, 0, 0);
        step(0, 0, 0, 0, 0, 32'd0); exp_redir(0, 0, 0);

        // Saturation of the 3-bit stall counter
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 0, 0, 0, 32'd0);
        end
        step(0, 0, 0, 0, 0, 32'd0);
        lit_scs_en = 1'b1; lit_scs = 7;
        lit_sc_en  = 1'b1; lit_sc  = 10;

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline hazard controller that produces the `stall[5:0]` vector and the `flush` pulse consumed by every inter-stage register (pc, if_id, id_ex, ex_mem, mem_wb). It arbitrates stall requests from IF (icache miss), ID (load-use), EX (multi-cycle op) and MEM (dcache miss), and handles branch redirects resolved in EX. A redirect that arrives while IF is busy is held in a pending register and replayed when the fetch completes. It also keeps saturating stall-cycle and flush counters for performance debug.

## Interface
Parameters:
- `STALL_CNT_W`, 32: width of the stall-cycle counter.
- `FLUSH_CNT_W`, 16: width of the flush counter.

Ports:
- `clk`  in  1: the single clock; all state updates on its rising edge.
- `rst`  in  1: reset, asynchronous, active-low (`rst`==0 resets).
- `stallreq_if`  in  1: icache busy or miss.
- `stallreq_id`  in  1: load-use hazard.
- `stallreq_ex`  in  1: multi-cycle EX op.
- `stallreq_mem`  in  1: dcache busy or miss.
- `branch_flag_i`  in  1: EX resolved a taken branch or jump this cycle.
- `branch_target_i`  in  32: redirect address (`InstAddrBus`).
- `stall`  out  6: bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb; 1 = Stop.
- `flush`  out  1: kill if_id and id_ex contents (bubble).
- `new_pc_o`  out  32: redirect target.
- `new_pc_valid`  out  1: pc register loads `new_pc_o` this edge.
- `stall_cycles`  out  `STALL_CNT_W`: cycles with `stall`!=0, saturating.
- `flush_count`  out  `FLUSH_CNT_W`: cycles with `flush`=1, saturating.

## Operation
- Stall priority, highest first. The first active request wins.
  - `stallreq_mem`: 6'b011111.
  - `stallreq_ex`: 6'b001111.
  - `stallreq_id`: 6'b000111.
  - `stallreq_if`: 6'b000011.
  - No request: 6'b000000.
- Branch acceptance: `br_ok` = `branch_flag_i` & ~`stallreq_mem` & ~`stallreq_ex`. A branch that is not accepted is ignored. EX is frozen in that case, so it re-presents the branch later.
- FSM states: `IDLE` and `WAIT_IF`.
- In `IDLE`, when `br_ok`=1:
  - Assert `flush`=1.
  - Mask `stallreq_id`, because the ID instruction is on the wrong path.
  - If `stallreq_if`=0: `new_pc_valid`=1 and `new_pc_o`=`branch_target_i`; stay in `IDLE`.
  - If `stallreq_if`=1: `new_pc_valid`=0; capture `pend_pc`<=`branch_target_i`; go to `WAIT_IF`.
- In `WAIT_IF`:
  - `stall` follows normal priority.
  - While `stallreq_if`=1: `flush`=0 and `new_pc_valid`=0.
  - When `stallreq_if`=0 and no mem/ex stall: `flush`=1 (the returning fetch is wrong-path), `new_pc_valid`=1, `new_pc_o`=`pend_pc`; go to `IDLE`.
  - A `br_ok` in `WAIT_IF` overwrites `pend_pc` (newest wins). The replay rules still apply.
- `stall`, `flush`, `new_pc_o` and `new_pc_valid` are combinational from the inputs, the state and `pend_pc`. `new_pc_o` is 0 when `new_pc_valid`=0.
- Counters increment by 1 per qualifying cycle and hold at all-ones; they never wrap.

## Timing
- Reset (async, `rst`=0):
  - State = `IDLE`, `pend_pc`=0, `stall_cycles`=0, `flush_count`=0.
  - `stall`=0, `flush`=0, `new_pc_valid`=0, `new_pc_o`=0, forced regardless of inputs.
- Reset asserted while in `WAIT_IF` discards the pending redirect.
- Zero-cycle latency from a request to `stall`/`flush`. The consumer registers act at the same rising edge.
- `flush` lasts exactly one cycle per accepted redirect. A direct redirect gives one pulse; a deferred redirect gives two (capture cycle and replay cycle).
- State, `pend_pc` and counters update at the rising edge of `clk` only.

## Test plan
- **Priority.** `stallreq_if`=`stallreq_id`=`stallreq_ex`=`stallreq_mem`=1 → `stall`=6'b011111. Drop mem → 6'b001111. Drop ex → 6'b000111. Drop id → 6'b000011.
- **Direct branch.** `branch_flag_i`=1, target 32'h0000_0040, all requests 0 → same cycle `flush`=1, `new_pc_valid`=1, `new_pc_o`=32'h40. `flush_count` goes 0→1 at the next edge.
- **Deferred branch.** Branch to 32'h80 with `stallreq_if`=1 held for 3 cycles:
  - Cycle 0: `flush`=1, `new_pc_valid`=0, `stall`=6'b000011.
  - Cycles 1-2: `flush`=0.
  - When `stallreq_if` drops: `flush`=1, `new_pc_valid`=1, `new_pc_o`=32'h80, state back to `IDLE`.
  - `flush_count`=2 at the end.
- **Branch blocked.** Branch with `stallreq_mem`=1 → `flush`=0, `new_pc_valid`=0. Next cycle with mem released and branch still asserted → redirect taken.
- **Load-use vs branch.** `stallreq_id`=1 and `br_ok`=1 → `stall`=6'b000000, `flush`=1.
- **Reset and saturation.**
  - Enter `WAIT_IF`, pulse `rst`=0 mid-cycle → outputs 0 immediately. After release, `stallreq_if` falling gives no replay.
  - With `STALL_CNT_W`=3, hold `stallreq_if`=1 for 10 cycles → `stall_cycles`=7.
